// File: rtl/rtc_alarm_sched.sv
// rtl/rtc_alarm_sched.sv - per-second alarm slot scanner with round-robin irq grant
module rtc_alarm_sched #(
    parameter int N_ALARMS = 4,
    parameter int ID_W     = 2
) (
    input  logic                  clk_i,
    input  logic                  rstn_i,
    input  logic                  tick_i,
    input  logic [5:0]            cur_sec_i,
    input  logic [5:0]            cur_min_i,
    input  logic [5:0]            cur_hour_i,
    input  logic [2:0]            cur_dow_i,
    input  logic [N_ALARMS*32-1:0] alarm_cfg_i,
    input  logic [N_ALARMS-1:0]   pend_clr_i,
    input  logic                  irq_ack_i,
    input  logic                  ovr_clr_i,
    output logic                  irq_o,
    output logic [ID_W-1:0]       irq_id_o,
    output logic [N_ALARMS-1:0]   pending_o,
    output logic                  busy_o,
    output logic                  overrun_o
);

    typedef enum logic {IDLE, SCAN} state_e;

    state_e                state_q, state_d;
    logic [ID_W-1:0]       idx_q, idx_d;
    logic [5:0]            snap_sec_q, snap_sec_d;
    logic [5:0]            snap_min_q, snap_min_d;
    logic [5:0]            snap_hour_q, snap_hour_d;
    logic [2:0]            snap_dow_q, snap_dow_d;
    logic [N_ALARMS-1:0]   pend_q, pend_d;
    logic                  irq_q, irq_d;
    logic [ID_W-1:0]       irq_id_q, irq_id_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic                  ovr_q, ovr_d;

    logic [31:0]           cfg_sel;
    logic [3:0]            sel_mask;
    logic                  slot_hit;
    logic [N_ALARMS-1:0]   match_vec;
    logic [N_ALARMS-1:0]   en_vec;
    logic                  unused_reserved;

    always_comb begin
        for (int k = 0; k < N_ALARMS; k++) begin
            en_vec[k] = alarm_cfg_i[32*k+25];
        end
    end

    assign cfg_sel         = alarm_cfg_i[32*int'(idx_q) +: 32];
    assign sel_mask        = cfg_sel[24:21];
    assign unused_reserved = ^cfg_sel[31:26];

    // Masked fields compare as always-equal; the snapshot isolates the scan from time changes.
    assign slot_hit = (state_q == SCAN) && cfg_sel[25]
                   && (sel_mask[0] || (cfg_sel[5:0]   == snap_sec_q))
                   && (sel_mask[1] || (cfg_sel[11:6]  == snap_min_q))
                   && (sel_mask[2] || (cfg_sel[17:12] == snap_hour_q))
                   && (sel_mask[3] || (cfg_sel[20:18] == snap_dow_q));

    always_comb begin
        match_vec = '0;
        if (slot_hit) begin
            match_vec[idx_q] = 1'b1;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        snap_sec_d  = snap_sec_q;
        snap_min_d  = snap_min_q;
        snap_hour_d = snap_hour_q;
        snap_dow_d  = snap_dow_q;
        ovr_d       = ovr_q;
        if (ovr_clr_i) begin
            ovr_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (tick_i) begin
                    snap_sec_d  = cur_sec_i;
                    snap_min_d  = cur_min_i;
                    snap_hour_d = cur_hour_i;
                    snap_dow_d  = cur_dow_i;
                    idx_d       = '0;
                    state_d     = SCAN;
                end
            end
            SCAN: begin
                if (tick_i) begin
                    ovr_d = 1'b1;
                end
                if (idx_q == ID_W'(N_ALARMS - 1)) begin
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < N_ALARMS; k++) begin
            pend_d[k] = pend_q[k];
            if (match_vec[k]) begin
                pend_d[k] = 1'b1;
            end else if (pend_clr_i[k] || !en_vec[k]) begin
                pend_d[k] = 1'b0;
            end else if (irq_q && irq_ack_i && (irq_id_q == ID_W'(k))) begin
                pend_d[k] = 1'b0;
            end
        end
    end

    always_comb begin
        logic found;
        int   j;
        irq_d    = irq_q;
        irq_id_d = irq_id_q;
        ptr_d    = ptr_q;
        found    = 1'b0;
        j        = 0;
        if (irq_q) begin
            if (irq_ack_i) begin
                irq_d = 1'b0;
                ptr_d = (irq_id_q == ID_W'(N_ALARMS - 1)) ? '0 : irq_id_q + 1'b1;
            end else if (!pend_d[irq_id_q]) begin
                irq_d = 1'b0;
            end
        end else if (pend_q != '0) begin
            // Search starts at the pointer and wraps, so the slot after the last acked one goes first.
            for (int i = 0; i < N_ALARMS; i++) begin
                j = int'(ptr_q) + i;
                if (j >= N_ALARMS) begin
                    j = j - N_ALARMS;
                end
                if (!found && pend_q[j]) begin
                    found    = 1'b1;
                    irq_id_d = ID_W'(j);
                end
            end
            irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            snap_sec_q  <= '0;
            snap_min_q  <= '0;
            snap_hour_q <= '0;
            snap_dow_q  <= '0;
            pend_q      <= '0;
            irq_q       <= 1'b0;
            irq_id_q    <= '0;
            ptr_q       <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_sec_q  <= snap_sec_d;
            snap_min_q  <= snap_min_d;
            snap_hour_q <= snap_hour_d;
            snap_dow_q  <= snap_dow_d;
            pend_q      <= pend_d;
            irq_q       <= irq_d;
            irq_id_q    <= irq_id_d;
            ptr_q       <= ptr_d;
            ovr_q       <= ovr_d;
        end
    end

    assign irq_o     = irq_q;
    assign irq_id_o  = irq_id_q;
    assign pending_o = pend_q;
    assign busy_o    = (state_q == SCAN);
    assign overrun_o = ovr_q;

endmodule
